// File: rtl/lcd_seq_writer.sv
// lcd_seq_writer
//   Burst writer that copies a host-loaded table of DEPTH bytes into the LCD
//   display RAM at consecutive addresses starting from BASE_ADDR.
//
// Optional feature macro: LCD_SEQ_REFRESH_EN
//   When defined, a finished pass restarts from entry 0 with the same length
//   (continuous refresh) until stop is seen high in the FIN cycle. The table
//   can then only be written during the FIN cycle.
//
// Ports
//   clk2      clock, all logic on its rising edge
//   rst       synchronous active-high reset
//   stop      (LCD_SEQ_REFRESH_EN only) leave the refresh loop after this pass
//   tbl_we    table write strobe, honoured only while no burst is running
//   tbl_addr  table write index (indices >= DEPTH are dropped)
//   tbl_data  table write data
//   start     begin a burst, honoured only when idle
//   len       number of entries to write, clamped to DEPTH
//   wr_rdy    RAM accepts the presented write this cycle
//   wr1       RAM write valid
//   addr1     RAM write address, BASE_ADDR + index modulo 2^ADDR_W
//   dbi1      RAM write data
//   busy      burst in progress
//   done      one-cycle pulse when a burst (pass) completes
//   led       sticky flag: a burst has completed since reset
module lcd_seq_writer #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int               LEN_W     = $clog2(DEPTH + 1),
  localparam int               TA_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk2,
  input  logic              rst,
`ifdef LCD_SEQ_REFRESH_EN
  input  logic              stop,
`endif
  input  logic              tbl_we,
  input  logic [TA_W-1:0]   tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              wr_rdy,
  output logic              wr1,
  output logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] dbi1,
  output logic              busy,
  output logic              done,
  output logic              led
);

  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] tbl [DEPTH];
  logic              tbl_wen;
  logic [DATA_W-1:0] tbl0_rd;

  logic              vld_p0;
  logic [LEN_W-1:0]  len_p0;

  logic [TA_W-1:0]   index, index_nx, idx_inc;
  logic [LEN_W-1:0]  n, n_nx;
  logic              last;
  logic              wr1_nx, busy_nx, done_nx, led_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] dbi_nx;

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : l;
  endfunction

  function automatic logic [ADDR_W-1:0] ram_addr(input logic [TA_W-1:0] i);
    return BASE_ADDR + ADDR_W'(i);
  endfunction

`ifdef LCD_SEQ_REFRESH_EN
  assign tbl_wen = tbl_we && (state == FIN) && (int'(tbl_addr) < DEPTH);
`else
  assign tbl_wen = tbl_we && !busy && (int'(tbl_addr) < DEPTH);
`endif

  // A write landing on entry 0 at the edge a new pass begins must be seen by
  // that pass, so bypass the array for the entry-0 read.
  assign tbl0_rd = (tbl_wen && (tbl_addr == '0)) ? tbl_data : tbl[0];

  always_ff @(posedge clk2) begin
    if (tbl_wen) tbl[tbl_addr] <= tbl_data;
  end

  // Stage p0: capture start/len; start is dropped unless the FSM is idle.
  always_ff @(posedge clk2) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= start && (state == IDLE);
    len_p0 <= len;
  end

  always_comb begin
    state_nx = state;
    index_nx = index;
    n_nx     = n;
    wr1_nx   = wr1;
    busy_nx  = busy;
    done_nx  = 1'b0;
    led_nx   = led;
    addr_nx  = addr1;
    dbi_nx   = dbi1;
    idx_inc  = index + 1'b1;
    last     = (LEN_W'(index) + LEN_W'(1)) == n;
    case (state)
      IDLE: begin
        if (vld_p0) begin
          n_nx     = sat_len(len_p0);
          index_nx = '0;
          if (len_p0 == '0) begin
            state_nx = FIN;
            done_nx  = 1'b1;
            led_nx   = 1'b1;
          end else begin
            state_nx = WRITE;
            wr1_nx   = 1'b1;
            busy_nx  = 1'b1;
            addr_nx  = ram_addr('0);
            dbi_nx   = tbl0_rd;
          end
        end
      end
      WRITE: begin
        if (wr1 && wr_rdy) begin
          if (last) begin
            state_nx = FIN;
            wr1_nx   = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            led_nx   = 1'b1;
          end else begin
            index_nx = idx_inc;
            addr_nx  = ram_addr(idx_inc);
            dbi_nx   = tbl[idx_inc];
          end
        end
      end
      FIN: begin
`ifdef LCD_SEQ_REFRESH_EN
        if (stop) begin
          state_nx = IDLE;
        end else begin
          state_nx = WRITE;
          index_nx = '0;
          wr1_nx   = 1'b1;
          busy_nx  = 1'b1;
          addr_nx  = ram_addr('0);
          dbi_nx   = tbl0_rd;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p1: FSM state and registered RAM-side outputs.
  always_ff @(posedge clk2) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
      n     <= '0;
      wr1   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      led   <= 1'b0;
      addr1 <= '0;
      dbi1  <= '0;
    end else begin
      state <= state_nx;
      index <= index_nx;
      n     <= n_nx;
      wr1   <= wr1_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      led   <= led_nx;
      addr1 <= addr_nx;
      dbi1  <= dbi_nx;
    end
  end

endmodule

// File: tb/tb_lcd_seq_writer.sv
// tb_lcd_seq_writer
//   Directed bench for lcd_seq_writer. Two instances share all inputs: u0 with
//   BASE_ADDR=00 and u1 with BASE_ADDR=FC (address wrap). Expected writes are
//   queued when a burst is started and popped as the RAM side accepts them.
module tb_lcd_seq_writer;

  logic       clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  logic       rst, tbl_we, start, wr_rdy, stop;
  logic [3:0] tbl_addr;
  logic [7:0] tbl_data;
  logic [4:0] len;
  logic       wr1, busy, done, led;
  logic [7:0] addr1, dbi1;
  logic       wr1_b, busy_b, done_b, led_b;
  logic [7:0] addr1_b, dbi1_b;

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] d;
  } exp_t;
  exp_t       q[$];
  logic [7:0] model [16];

  lcd_seq_writer #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .BASE_ADDR(8'h00)) u0 (
    .clk2(clk2), .rst(rst),
`ifdef LCD_SEQ_REFRESH_EN
    .stop(stop),
`endif
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .len(len), .wr_rdy(wr_rdy),
    .wr1(wr1), .addr1(addr1), .dbi1(dbi1), .busy(busy), .done(done), .led(led)
  );

  lcd_seq_writer #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .BASE_ADDR(8'hFC)) u1 (
    .clk2(clk2), .rst(rst),
`ifdef LCD_SEQ_REFRESH_EN
    .stop(stop),
`endif
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .len(len), .wr_rdy(wr_rdy),
    .wr1(wr1_b), .addr1(addr1_b), .dbi1(dbi1_b), .busy(busy_b), .done(done_b), .led(led_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk2);
    #1;
  endtask

  task automatic load(input int i, input logic [7:0] d);
`ifdef LCD_SEQ_REFRESH_EN
    // Table is writable only in FIN: run an empty burst to get there.
    start = 1'b1; len = 5'd0;
    tick;
    start = 1'b0;
    tick;
`endif
    tbl_we = 1'b1; tbl_addr = i[3:0]; tbl_data = d;
    tick;
    tbl_we = 1'b0;
    model[i] = d;
  endtask

  task automatic burst(input string tag, input int l, input int stall_n, input logic [7:0] stall_a,
                       input bit co_we, input logic [3:0] co_a, input logic [7:0] co_d);
    int   n, hi, first, stalls;
    bit   seen;
    exp_t e;
    n = (l > 16) ? 16 : l;
    if (co_we) model[co_a] = co_d;
    for (int i = 0; i < n; i++) begin
      e.a0 = 8'(i);
      e.a1 = 8'(8'hFC + i);
      e.d  = model[i];
      q.push_back(e);
    end
    start = 1'b1; len = l[4:0];
    tbl_we = co_we; tbl_addr = co_a; tbl_data = co_d;
    tick;
    start = 1'b0; tbl_we = 1'b0;
    hi = 0; first = -1; stalls = stall_n; seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (wr1 && addr1 == stall_a && stalls > 0) begin
        wr_rdy = 1'b0;
        stalls--;
      end else begin
        wr_rdy = 1'b1;
      end
      @(negedge clk2);
      if ((wr1 || done) && first < 0) first = c;
      if (wr1) begin
        hi++;
        chk({tag, " busy"}, busy, 1);
        vecs++;
        assert (q.size() > 0) else begin
          errs++;
          $error("FAIL %s extra_write: observed addr %0h expected no write", tag, addr1);
        end
        if (q.size() > 0) begin
          if (wr_rdy) begin
            e = q.pop_front();
            chk({tag, " addr1"}, addr1, e.a0);
            chk({tag, " addr1_wrap"}, addr1_b, e.a1);
            chk({tag, " dbi1"}, dbi1, e.d);
          end else begin
            chk({tag, " hold_addr"}, addr1, q[0].a0);
            chk({tag, " hold_dbi"}, dbi1, q[0].d);
          end
        end
      end
      if (done) seen = 1'b1;
      @(posedge clk2);
      #1;
    end
    wr_rdy = 1'b1;
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " latency"}, first, 1);
    chk({tag, " wr_cycles"}, hi, n + stall_n);
    chk({tag, " left_in_queue"}, q.size(), 0);
    chk({tag, " led"}, led, 1);
    chk({tag, " wr1_after"}, wr1, 0);
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " done_one_cycle"}, done, 0);
    q.delete();
  endtask

  initial begin
    bit   hit;
    exp_t e;
    rst = 1'b1; tbl_we = 1'b0; start = 1'b0; wr_rdy = 1'b1; stop = 1'b1;
    tbl_addr = '0; tbl_data = '0; len = '0;
    tick; tick;
    chk("rst wr1", wr1, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst led", led, 0);
    chk("rst addr1", addr1, 0);
    chk("rst dbi1", dbi1, 0);
    rst = 1'b0;
    tick;

    load(0, 8'h08); load(1, 8'h00); load(2, 8'h4A); load(3, 8'h61);
    load(4, 8'h62); load(5, 8'h6F); load(6, 8'h6E); load(7, 8'h20);
    load(8, 8'h24); load(9, 8'h04);
    for (int i = 10; i < 16; i++) load(i, 8'(8'h90 + i));

    burst("basic", 10, 0, 8'hFF, 1'b0, 4'd0, 8'h00);
    burst("stall", 10, 3, 8'h03, 1'b0, 4'd0, 8'h00);
    burst("len0", 0, 0, 8'hFF, 1'b0, 4'd0, 8'h00);
    burst("len_clamp", 31, 0, 8'hFF, 1'b0, 4'd0, 8'h00);
    burst("wrap6", 6, 0, 8'hFF, 1'b0, 4'd0, 8'h00);

    // Reset in the middle of a burst; start and table write during it ignored.
    start = 1'b1; len = 5'd10;
    tick;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (wr1 && addr1 == 8'h05) hit = 1'b1;
      else tick;
    end
    chk("mid reached_entry5", hit, 1);
    tbl_we = 1'b1; tbl_addr = 4'd0; tbl_data = 8'hFF; start = 1'b1; len = 5'd3;
    tick;
    tbl_we = 1'b0; start = 1'b0;
    chk("mid busy", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk2);
    chk("mid rst wr1", wr1, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst led", led, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk2);
      chk("mid no_done", done, 0);
      chk("mid no_wr1", wr1, 0);
    end
    tick;
    burst("restart", 10, 0, 8'hFF, 1'b0, 4'd0, 8'h00);

`ifndef LCD_SEQ_REFRESH_EN
    burst("cowrite0", 4, 0, 8'hFF, 1'b1, 4'd0, 8'h5A);
    burst("cowrite2", 4, 0, 8'hFF, 1'b1, 4'd2, 8'hC3);
`endif

`ifdef LCD_SEQ_REFRESH_EN
    begin
      int dones;
      stop = 1'b0;
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < 3; i++) begin
          e.a0 = 8'(i); e.a1 = 8'(8'hFC + i); e.d = model[i];
          q.push_back(e);
        end
      end
      start = 1'b1; len = 5'd3;
      tick;
      start = 1'b0;
      dones = 0;
      for (int c = 0; c < 100 && dones < 2; c++) begin
        if (dones == 1) stop = 1'b1;
        @(negedge clk2);
        if (wr1) begin
          vecs++;
          assert (q.size() > 0) else begin
            errs++;
            $error("FAIL refresh extra_write: observed addr %0h expected no write", addr1);
          end
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("refresh addr1", addr1, e.a0);
            chk("refresh dbi1", dbi1, e.d);
          end
        end
        if (done) dones++;
        @(posedge clk2);
        #1;
      end
      chk("refresh passes", dones, 2);
      chk("refresh left_in_queue", q.size(), 0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk2);
        chk("refresh stopped wr1", wr1, 0);
        chk("refresh stopped busy", busy, 0);
      end
      q.delete();
      stop = 1'b1;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
